// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl
//   Sequences one voting session for an external 4-input majority voter.
//   A session opens on start, collects at most one vote per voter over a
//   per-voter valid/ack handshake (closing early once all four have voted, or
//   after TIMEOUT_CYCLES collect cycles), presents the frozen ballot to the
//   combinational voter for one evaluation cycle, registers the verdict and
//   holds it on a valid/ready result port.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset; discards any session in flight
//   start         open a session (sampled only while idle)
//   vote_valid    per-voter vote present
//   vote_val      per-voter vote value, 1 = yes
//   vote_ack      per-voter one-cycle acceptance pulse (registered)
//   busy          session in progress (collect, evaluate or hold)
//   ballot        frozen yes-bits to the voter; absent voters read as 0
//   voter_result  voter verdict, one-hot: 100 fail, 010 tie, 001 pass
//   res_valid     result available
//   res_ready     consumer takes the result
//   res_code      registered verdict (000 when the verdict was malformed)
//   res_voted     mask of voters that voted in the session
//   res_timeout   session closed by timeout rather than by a full vote
//   res_err       verdict was not one-hot
module vote_session_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] vote_valid,
  input  logic [3:0] vote_val,
  output logic [3:0] vote_ack,
  output logic       busy,
  output logic [3:0] ballot,
  input  logic [2:0] voter_result,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [2:0] res_code,
  output logic [3:0] res_voted,
  output logic       res_timeout,
  output logic       res_err
);

  typedef enum logic [1:0] {StIdle, StCollect, StEval, StHold} state_e;

  // Counter value seen during the last permitted collect cycle.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       ballot_q, ballot_d;
  logic [3:0]       voted_q, voted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ack_q, ack_d;
  logic [2:0]       res_code_q, res_code_d;
  logic [3:0]       res_voted_q, res_voted_d;
  logic             res_timeout_q, res_timeout_d;
  logic             res_err_q, res_err_d;

  logic [3:0] accept;
  logic [3:0] voted_all;
  logic       full_close;
  logic       timeout_close;
  logic       result_onehot;

  // Only first votes from voters not yet counted are accepted, and only while collecting.
  assign accept        = (state_q == StCollect) ? (vote_valid & ~voted_q) : 4'b0000;
  assign voted_all     = voted_q | accept;
  assign full_close    = (voted_all == 4'hF);
  assign timeout_close = (cnt_q == CntLast);
  assign result_onehot = (voter_result == 3'b001) || (voter_result == 3'b010) ||
                         (voter_result == 3'b100);

  always_comb begin
    state_d       = state_q;
    ballot_d      = ballot_q;
    voted_d       = voted_q;
    cnt_d         = cnt_q;
    ack_d         = 4'b0000;
    res_code_d    = res_code_q;
    res_voted_d   = res_voted_q;
    res_timeout_d = res_timeout_q;
    res_err_d     = res_err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCollect;
          ballot_d = 4'b0000;
          voted_d  = 4'b0000;
          cnt_d    = '0;
        end
      end

      StCollect: begin
        ballot_d = (ballot_q & ~accept) | (vote_val & accept);
        voted_d  = voted_all;
        cnt_d    = cnt_q + 1'b1;
        ack_d    = accept;
        // A full vote on the final collect cycle still counts as a normal close.
        if (full_close) begin
          state_d       = StEval;
          res_timeout_d = 1'b0;
        end else if (timeout_close) begin
          state_d       = StEval;
          res_timeout_d = 1'b1;
        end
      end

      StEval: begin
        res_code_d  = result_onehot ? voter_result : 3'b000;
        res_err_d   = ~result_onehot;
        res_voted_d = voted_q;
        state_d     = StHold;
      end

      StHold: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ballot_q      <= 4'b0000;
      voted_q       <= 4'b0000;
      cnt_q         <= '0;
      ack_q         <= 4'b0000;
      res_code_q    <= 3'b000;
      res_voted_q   <= 4'b0000;
      res_timeout_q <= 1'b0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ballot_q      <= ballot_d;
      voted_q       <= voted_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      res_code_q    <= res_code_d;
      res_voted_q   <= res_voted_d;
      res_timeout_q <= res_timeout_d;
      res_err_q     <= res_err_d;
    end
  end

  assign vote_ack    = ack_q;
  assign busy        = (state_q != StIdle);
  assign ballot      = ballot_q;
  assign res_valid   = (state_q == StHold);
  assign res_code    = res_code_q;
  assign res_voted   = res_voted_q;
  assign res_timeout = res_timeout_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
module tb_vote_session_ctrl;

  localparam int TO = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] vote_valid;
  logic [3:0] vote_val;
  logic [3:0] vote_ack;
  logic       busy;
  logic [3:0] ballot;
  logic [2:0] voter_result;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_code;
  logic [3:0] res_voted;
  logic       res_timeout;
  logic       res_err;

  int checks = 0;
  int errors = 0;

  // Environment voter, optionally overridden with a malformed verdict.
  logic       force_bad;
  logic [2:0] bad_code;

  // Per-cycle vote schedule for the session under test (index = collect cycle).
  logic [3:0] sch_valid [16];
  logic [3:0] sch_val   [16];

  function automatic logic [2:0] maj(input logic [3:0] b);
    int n;
    n = $countones(b);
    if (n > 2) return 3'b001;
    if (n == 2) return 3'b010;
    return 3'b100;
  endfunction

  assign voter_result = force_bad ? bad_code : maj(ballot);

  vote_session_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .vote_valid  (vote_valid),
    .vote_val    (vote_val),
    .vote_ack    (vote_ack),
    .busy        (busy),
    .ballot      (ballot),
    .voter_result(voter_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_code    (res_code),
    .res_voted   (res_voted),
    .res_timeout (res_timeout),
    .res_err     (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {13'd0, vote_ack, busy, ballot, res_valid, res_code, res_voted, res_timeout,
               res_err}, 32'd0);
  endtask

  task automatic clear_sched();
    for (int k = 0; k < 16; k++) begin
      sch_valid[k] = 4'b0000;
      sch_val[k]   = 4'b0000;
    end
  endtask

  // Runs one full session from IDLE using sch_valid/sch_val. Expectations come from
  // each voter's first presentation within the collect window.
  task automatic session(input string name, input int ready_delay);
    int         first [4];
    logic [3:0] bits;
    logic [3:0] exp_voted;
    logic [3:0] exp_ballot;
    logic [3:0] exp_ack;
    logic [2:0] exp_code;
    logic       exp_err;
    logic       exp_to;
    int         last;
    int         close_c;
    bit         all_in;

    bits = 4'b0000;
    for (int i = 0; i < 4; i++) first[i] = -1;
    for (int k = 0; k < TO; k++)
      for (int i = 0; i < 4; i++)
        if (first[i] < 0 && sch_valid[k][i]) begin
          first[i] = k;
          bits[i]  = sch_val[k][i];
        end
    all_in    = 1'b1;
    last      = 0;
    exp_voted = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (first[i] < 0) all_in = 1'b0;
      else begin
        exp_voted[i] = 1'b1;
        if (first[i] > last) last = first[i];
      end
    end
    close_c    = all_in ? last : TO - 1;
    exp_to     = !all_in;
    exp_ballot = bits & exp_voted;
    exp_err    = force_bad && !$onehot(bad_code);
    exp_code   = exp_err ? 3'b000 : (force_bad ? bad_code : maj(exp_ballot));

    start      = 1'b1;
    vote_valid = 4'b0000;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " busy_open"}, busy, 1'b1);
    chk({name, " ballot_clr"}, ballot, 4'b0000);

    for (int k = 0; k <= close_c; k++) begin
      vote_valid = sch_valid[k];
      vote_val   = sch_val[k];
      @(posedge clk); #1;
      exp_ack = 4'b0000;
      for (int i = 0; i < 4; i++) if (first[i] == k) exp_ack[i] = 1'b1;
      chk($sformatf("%s ack[%0d]", name, k), vote_ack, exp_ack);
      chk($sformatf("%s res_valid_low[%0d]", name, k), res_valid, 1'b0);
    end

    // Now evaluating: new votes must be ignored.
    vote_valid = 4'hF;
    vote_val   = 4'($urandom);
    chk({name, " busy_eval"}, busy, 1'b1);
    @(posedge clk); #1;
    vote_valid = 4'b0000;
    chk({name, " ack_after_close"}, vote_ack, 4'b0000);
    chk({name, " res_valid"}, res_valid, 1'b1);
    chk({name, " res_code"}, res_code, exp_code);
    chk({name, " res_voted"}, res_voted, exp_voted);
    chk({name, " res_timeout"}, res_timeout, exp_to);
    chk({name, " res_err"}, res_err, exp_err);
    chk({name, " ballot"}, ballot, exp_ballot);

    for (int d = 0; d < ready_delay; d++) begin
      start     = 1'b1;
      res_ready = 1'b0;
      @(posedge clk); #1;
      chk({name, " hold_valid"}, res_valid, 1'b1);
      chk({name, " hold_fields"}, {res_code, res_voted, res_timeout, res_err, ballot},
          {exp_code, exp_voted, exp_to, exp_err, exp_ballot});
    end
    start     = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk({name, " valid_drop"}, res_valid, 1'b0);
    chk({name, " busy_idle"}, busy, 1'b0);
    chk({name, " after_fields"}, {res_code, res_voted, res_timeout, res_err, ballot},
        {exp_code, exp_voted, exp_to, exp_err, exp_ballot});
  endtask

  typedef struct {
    logic [3:0] val;
    logic [2:0] code;
  } ballot_vec_t;

  ballot_vec_t tbl [16];

  initial begin
    tbl[0]  = '{4'b0000, 3'b100}; tbl[1]  = '{4'b0001, 3'b100};
    tbl[2]  = '{4'b0010, 3'b100}; tbl[3]  = '{4'b0011, 3'b010};
    tbl[4]  = '{4'b0100, 3'b100}; tbl[5]  = '{4'b0101, 3'b010};
    tbl[6]  = '{4'b0110, 3'b010}; tbl[7]  = '{4'b0111, 3'b001};
    tbl[8]  = '{4'b1000, 3'b100}; tbl[9]  = '{4'b1001, 3'b010};
    tbl[10] = '{4'b1010, 3'b010}; tbl[11] = '{4'b1011, 3'b001};
    tbl[12] = '{4'b1100, 3'b010}; tbl[13] = '{4'b1101, 3'b001};
    tbl[14] = '{4'b1110, 3'b001}; tbl[15] = '{4'b1111, 3'b001};

    rst_n      = 1'b0;
    start      = 1'b0;
    vote_valid = 4'b0000;
    vote_val   = 4'b0000;
    res_ready  = 1'b0;
    force_bad  = 1'b0;
    bad_code   = 3'b000;
    clear_sched();

    @(posedge clk); #1;
    chk_all_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("idle_after_reset");

    // Start ignored? No: a vote offered while idle must get no ack.
    vote_valid = 4'hF;
    @(posedge clk); #1;
    vote_valid = 4'b0000;
    chk("idle_vote_ignored", {vote_ack, busy}, 5'd0);

    // All 16 ballots, all voters in the first collect cycle.
    for (int t = 0; t < 16; t++) begin
      clear_sched();
      sch_valid[0] = 4'hF;
      sch_val[0]   = tbl[t].val;
      session($sformatf("ballot_%0d", t), 0);
      chk($sformatf("tbl_code_%0d", t), res_code, tbl[t].code);
    end

    // Votes spread over three cycles, final ballot 0011.
    clear_sched();
    sch_valid[0] = 4'b0001; sch_val[0] = 4'b0001;
    sch_valid[1] = 4'b0110; sch_val[1] = 4'b0010;
    sch_valid[2] = 4'b1000; sch_val[2] = 4'b0000;
    session("spread", 1);
    chk("spread_code", res_code, 3'b010);
    chk("spread_voted", res_voted, 4'hF);

    // Only voters 0 and 1 vote: timeout close.
    clear_sched();
    sch_valid[0] = 4'b0011; sch_val[0] = 4'b0011;
    session("timeout", 0);
    chk("timeout_flag", {res_timeout, res_code, res_voted}, {1'b1, 3'b010, 4'b0011});

    // Last vote lands on the timeout cycle: full-vote close wins.
    clear_sched();
    sch_valid[0]      = 4'b0111; sch_val[0] = 4'b0011;
    sch_valid[TO - 1] = 4'b1000; sch_val[TO - 1] = 4'b1000;
    session("late_full", 0);
    chk("late_full_to", res_timeout, 1'b0);

    // Voter 2 holds valid with a changing value: one ack, first value kept.
    clear_sched();
    for (int k = 0; k < 5; k++) begin
      sch_valid[k] = 4'b0100;
      sch_val[k]   = (k % 2 == 0) ? 4'b0100 : 4'b0000;
    end
    sch_valid[5] = 4'b1011; sch_val[5] = 4'b0000;
    session("repeat_v2", 0);
    chk("repeat_v2_bit", ballot[2], 1'b1);

    // Slow consumer and a malformed verdict.
    clear_sched();
    sch_valid[0] = 4'hF; sch_val[0] = 4'b1110;
    force_bad = 1'b1;
    bad_code  = 3'b011;
    session("bad_verdict", 6);
    chk("bad_verdict_err", {res_err, res_code}, {1'b1, 3'b000});
    force_bad = 1'b0;

    // Asynchronous reset mid-collect with two votes taken.
    start = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    vote_valid = 4'b0001; vote_val = 4'b0001;
    @(posedge clk); #1;
    vote_valid = 4'b0100; vote_val = 4'b0100;
    @(posedge clk); #1;
    vote_valid = 4'b0000;
    chk("pre_reset_ballot", {busy, ballot}, {1'b1, 4'b0101});
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("post_reset_idle");
    clear_sched();
    sch_valid[0] = 4'b1001; sch_val[0] = 4'b1001;
    sch_valid[1] = 4'b0110; sch_val[1] = 4'b0010;
    session("post_reset", 2);

    // Randomized sessions.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 16; k++) begin
        sch_valid[k] = 4'($urandom) & 4'($urandom) & 4'($urandom);
        sch_val[k]   = 4'($urandom);
      end
      session($sformatf("rand_%0d", r), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
